// File: rtl/song_recorder_pkg.sv
// Shared types and constants for the song recorder.
package song_recorder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRecord,
        StPlay
    } state_e;

    localparam logic [3:0]  REST    = 4'd0;
    localparam int unsigned DUR_MAX = 255;
    localparam int unsigned ENTRY_W = 12;

    // Saturating increment of a segment duration in ticks.
    function automatic logic [7:0] dur_sat_inc(input logic [7:0] d);
        return (d == 8'(DUR_MAX)) ? d : d + 8'd1;
    endfunction

endpackage

// File: rtl/song_recorder_tick_gen.sv
// Free-running duration tick generator with synchronous clear.
module song_recorder_tick_gen
    import song_recorder_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntW'(TICK_CYCLES - 1));

    // Count up to TICK_CYCLES-1 and wrap; clear restarts a full tick period.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/song_recorder.sv
// Records key presses as {note, duration} segments and replays them.
module song_recorder
    import song_recorder_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 10_000_000,
    parameter int unsigned DEPTH       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_out,
    input  logic       key_out_on,
    input  logic       record_start,
    input  logic       stop,
    input  logic       play_start,
    output logic [3:0] note_to_play,
    output logic       play_note,
    output logic       recording,
    output logic       playing,
    output logic [5:0] entry_count,
    output logic       full,
    output logic       done
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e             state_q, state_d;
    logic [5:0]         count_q, count_d;
    logic               key_on_q;
    logic               seg_open_q, seg_open_d;
    logic [3:0]         seg_note_q, seg_note_d;
    logic [7:0]         dur_q, dur_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               done_q, done_d;
    logic               tick, tick_clr;
    logic               wr_en;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] rd_entry;
    logic [7:0]         dur_tick, dur_wr;
    logic               key_rise, key_fall, key_chg;

    song_recorder_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (tick_clr),
        .tick_o(tick)
    );

    assign rd_entry = mem_q[idx_q];
    // dur_q counts ticks in the current segment (record) or entry (play).
    assign dur_tick = tick ? dur_sat_inc(dur_q) : dur_q;
    assign dur_wr   = (dur_tick == 8'd0) ? 8'd1 : dur_tick;
    assign key_rise = key_out_on & ~key_on_q;
    assign key_fall = ~key_out_on & key_on_q;
    // Only a held note can change pitch; a key already down at record start is ignored.
    assign key_chg  = key_out_on & key_on_q & seg_open_q & (seg_note_q != REST)
                      & (key_out != seg_note_q);

    // Next-state: mode control, segment tracking and replay sequencing.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        seg_open_d = seg_open_q;
        seg_note_d = seg_note_q;
        dur_d      = dur_tick;
        idx_d      = idx_q;
        done_d     = 1'b0;
        tick_clr   = 1'b0;
        wr_en      = 1'b0;
        wr_data    = {seg_note_q, dur_wr};
        unique case (state_q)
            StIdle: begin
                if (record_start) begin
                    state_d    = StRecord;
                    count_d    = '0;
                    seg_open_d = 1'b0;
                    seg_note_d = REST;
                end else if (play_start && (count_q != 6'd0)) begin
                    state_d = StPlay;
                    idx_d   = '0;
                end
            end
            StRecord: begin
                if (stop) begin
                    // A trailing rest carries no information and is dropped.
                    wr_en   = seg_open_q && (seg_note_q != REST);
                    state_d = StIdle;
                end else if (key_rise || key_chg) begin
                    wr_en      = seg_open_q;
                    seg_open_d = 1'b1;
                    seg_note_d = key_out;
                    dur_d      = '0;
                    tick_clr   = 1'b1;
                end else if (key_fall && seg_open_q) begin
                    wr_en      = 1'b1;
                    seg_note_d = REST;
                    dur_d      = '0;
                    tick_clr   = 1'b1;
                end
                if (wr_en) begin
                    count_d = count_q + 6'd1;
                    if (count_d == 6'(DEPTH)) begin
                        state_d = StIdle;
                    end
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (tick && (dur_tick >= rd_entry[7:0])) begin
                    dur_d    = '0;
                    tick_clr = 1'b1;
                    if ((6'(idx_q) + 6'd1) == count_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            tick_clr = 1'b1;
            dur_d    = '0;
        end
    end

    // Control and segment registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            key_on_q   <= 1'b0;
            seg_open_q <= 1'b0;
            seg_note_q <= REST;
            dur_q      <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            key_on_q   <= key_out_on;
            seg_open_q <= seg_open_d;
            seg_note_q <= seg_note_d;
            dur_q      <= dur_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
        end
    end

    // Song memory; contents are qualified by entry_count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q[IdxW-1:0]] <= wr_data;
        end
    end

    assign recording    = (state_q == StRecord);
    assign playing      = (state_q == StPlay);
    assign note_to_play = playing ? rd_entry[11:8] : REST;
    assign play_note    = playing && (rd_entry[11:8] != REST);
    assign entry_count  = count_q;
    assign full         = (count_q == 6'(DEPTH));
    assign done         = done_q;

endmodule

// File: doc/song_recorder.md
SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 Parameter TICK_CYCLES, default 10_000_000; clk cycles per duration tick (100 ms at 100 MHz).
REQ-002 Parameter DEPTH, default 32; number of note/rest entries in song memory.
REQ-003 Port clk, input, 1; single system clock, all logic on its rising edge.
REQ-004 Port rst, input, 1; reset, asynchronous, active-high.
REQ-005 Port key_out, input, 4; note code from keyControl, 1-15 valid, 0 reserved as REST.
REQ-006 Port key_out_on, input, 1; level, high while a key is held.
REQ-007 Port record_start, input, 1; debounced one-cycle pulse, begin recording.
REQ-008 Port stop, input, 1; debounced one-cycle pulse, end recording or abort playback.
REQ-009 Port play_start, input, 1; debounced one-cycle pulse, begin replay of stored song.
REQ-010 Port note_to_play, output, 4; replayed note code, compatible with buzzer/ledControl.
REQ-011 Port play_note, output, 1; high while replayed entry is a non-REST note.
REQ-012 Port recording, output, 1; high in RECORD state.
REQ-013 Port playing, output, 1; high in PLAY state.
REQ-014 Port entry_count, output, 6; number of valid stored entries, 0..DEPTH.
REQ-015 Port full, output, 1; high when entry_count == DEPTH.
REQ-016 Port done, output, 1; one-cycle pulse when replay completes normally.

Function
REQ-017 States SHALL be IDLE, RECORD, PLAY; tick counter restarts on every state entry.
REQ-018 IDLE: record_start -> RECORD with entry_count cleared; play_start with entry_count>0 -> PLAY at index 0; play_start with entry_count==0 ignored.
REQ-019 Entry format SHALL be {note[3:0], dur[7:0]}; dur counts ticks, saturates at 255, written as max(dur,1).
REQ-020 RECORD: rising key_out_on SHALL close open segment (if any) and open note segment with key_out latched.
REQ-021 RECORD: falling key_out_on SHALL close note segment and open REST segment.
REQ-022 RECORD: key_out change while key_out_on stays high SHALL close current note and open new note segment.
REQ-023 No REST segment SHALL be opened before the first note; a leading silence is not stored.
REQ-024 Closing a segment SHALL write one entry at index entry_count and increment entry_count the next cycle.
REQ-025 Write making entry_count==DEPTH SHALL assert full and return to IDLE next cycle; further input ignored.
REQ-026 RECORD stop: open note segment written, open REST segment discarded, -> IDLE.
REQ-027 stop coincident with key edge SHALL take priority; edge ignored, REQ-026 applies.
REQ-028 PLAY: note_to_play = entry note, play_note = (note != 0), held dur ticks, then next index, no gap cycle.
REQ-029 After last entry expires: -> IDLE, note_to_play=0, play_note=0, done pulsed same cycle as transition.
REQ-030 PLAY stop: -> IDLE next cycle, outputs cleared, no done pulse; memory and entry_count retained.
REQ-031 record_start and play_start ignored outside IDLE; record_start and play_start together in IDLE: record wins.

Reset
REQ-032 rst SHALL force IDLE, entry_count=0, full=0, note_to_play=0, play_note=0, recording=0, playing=0, done=0, tick counter 0.
REQ-033 Memory contents need not reset; entry_count=0 marks them invalid.
REQ-034 rst mid-RECORD or mid-PLAY SHALL abort without writing the open segment.

Structure
REQ-035 Shared package SHALL hold state enum, REST code (4'd0), DUR_MAX (255), entry width (12).
REQ-036 One sub-module tick_gen SHALL produce a one-cycle tick every TICK_CYCLES with synchronous clear.
REQ-037 Song memory SHALL be a DEPTH x 12 register array, single write port, single read port.

Verification (TICK_CYCLES=4, DEPTH=4)
REQ-038 record_start; key 5 held 12 cycles; released 8 cycles; key 3 held 4; stop -> entries {5,3},{0,2},{3,1}, entry_count=3.
REQ-039 Replay of REQ-038 -> note 5 play_note=1 12 cycles, note 0 play_note=0 8 cycles, note 3 4 cycles, done pulse, IDLE.
REQ-040 Five short presses with DEPTH=4 -> full=1 after 4th entry, state IDLE, 5th press ignored.
REQ-041 Key held 2000 cycles -> stored dur=255; stop during PLAY at cycle 10 -> IDLE, no done, entry_count kept.
REQ-042 stop same cycle as rising key_out_on -> no new note stored; rst mid-PLAY -> all outputs 0 next cycle.
REQ-043 play_start with entry_count=0 -> stays IDLE, playing=0.
